// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes engine: block/byte widths, the byte
// type, the engine FSM state enum and the ShiftRows source-index helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W   = 128;
  localparam int unsigned AES_BYTE_W    = 8;
  localparam int unsigned AES_NUM_BYTES = 16;

  typedef logic [AES_BYTE_W-1:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Output byte k = (row k%4, col k/4) takes substituted byte (row, (col+row) mod 4).
  function automatic int unsigned shift_rows_src(input int unsigned k);
    return (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
  endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Block-stream bus for the SubBytes engine.
//   in_valid/in_ready/in_data    : input block handshake (master -> slave)
//   out_valid/out_ready/out_data : result block handshake (slave -> master)
// Modports: master = block producer/consumer, slave = engine.
interface sub_bytes_engine_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sbox.sv
// Forward AES S-box, purely combinational.
//   i_byte : byte to substitute
//   o_byte : S-box value
module sbox
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

  // Entry 0 sits in the top byte, so entry n lives at bit offset 8*(255-n) = {~n, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_lsb;

  assign w_lsb  = {~i_byte, 3'b000};
  assign o_byte = SBOX_TABLE[w_lsb +: 8];

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: captures a 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per BUSY cycle through parallel S-boxes, then holds the result until
// the downstream handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sub_bytes_engine_if.slave (in_* accept side, out_* result side)
//   busy       : high while a block is being processed or held for output
// Optional: define SUB_BYTES_SHIFT_ROWS_EN to apply ShiftRows on out_data.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sub_bytes_engine_if.slave        bus,
  output logic                     busy
);

  localparam int unsigned NUM_CHUNKS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned IDX_W      = $clog2(AES_NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if ((BYTES_PER_CYCLE != 1) && (BYTES_PER_CYCLE != 2) && (BYTES_PER_CYCLE != 4) &&
      (BYTES_PER_CYCLE != 8) && (BYTES_PER_CYCLE != 16)) begin : g_bad_bpc
    $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  aes_byte_t              r_bytes [AES_NUM_BYTES];
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;

  logic [IDX_W-1:0]       w_base;
  aes_byte_t              w_sb_in  [BYTES_PER_CYCLE];
  aes_byte_t              w_sb_out [BYTES_PER_CYCLE];
  logic [AES_BLOCK_W-1:0] w_out_data;

  // First byte index of the chunk selected by the counter.
  assign w_base = IDX_W'(int'(r_cnt) * int'(BYTES_PER_CYCLE));

  // Chunk mux feeding the S-box lanes.
  always_comb begin
    for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
      w_sb_in[j] = r_bytes[w_base + IDX_W'(j)];
    end
  end

  for (genvar j = 0; j < int'(BYTES_PER_CYCLE); j++) begin : g_sbox
    sbox u_sbox (
      .i_byte (w_sb_in[j]),
      .o_byte (w_sb_out[j])
    );
  end

  // Control FSM, state register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < int'(AES_NUM_BYTES); k++) begin
        r_bytes[IDX_W'(k)] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < int'(AES_NUM_BYTES); k++) begin
              r_bytes[IDX_W'(k)] <= bus.in_data[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W];
            end
            r_cnt      <= '0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
            r_bytes[w_base + IDX_W'(j)] <= w_sb_out[j];
          end
          // Counter parks on the last chunk; DONE never advances it.
          if (r_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Output byte packing, optionally permuted by ShiftRows (pure wiring).
  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < int'(AES_NUM_BYTES); k++) begin
`ifdef SUB_BYTES_SHIFT_ROWS_EN
      w_out_data[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W] =
        r_bytes[IDX_W'(shift_rows_src(k))];
`else
      w_out_data[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W] = r_bytes[IDX_W'(k)];
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_out_data;
  assign busy          = r_busy;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: table of hand-computed vectors on the
// default instance, handshake/reset corner sequences, and a byte sweep over
// instances with every legal BYTES_PER_CYCLE checked against an S-box built
// from GF(2^8) inversion plus the affine map.
`timescale 1ns/1ps
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic dut_busy;

  always #5 clk = ~clk;

  sub_bytes_engine_if dut_if ();

  sub_bytes_engine u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave),
    .busy  (dut_busy)
  );

  // Sweep instances, one per legal chunk width, sharing one stimulus.
  logic         sw_in_valid;
  logic [127:0] sw_in_data;
  logic         sw_out_ready;
  logic [4:0]   sw_ovalid, sw_iready, sw_busy;
  logic [127:0] sw_odata [5];

  for (genvar g = 0; g < 5; g++) begin : g_sw
    sub_bytes_engine_if sw_if ();
    assign sw_if.in_valid  = sw_in_valid;
    assign sw_if.in_data   = sw_in_data;
    assign sw_if.out_ready = sw_out_ready;
    assign sw_ovalid[g]    = sw_if.out_valid;
    assign sw_iready[g]    = sw_if.in_ready;
    assign sw_odata[g]     = sw_if.out_data;
    sub_bytes_engine #(.BYTES_PER_CYCLE(1 << g)) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_if.slave),
      .busy  (sw_busy[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_sb [256];

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp_sb;
    logic [127:0] exp_sr;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] expected_of(input logic [127:0] din);
    logic [127:0] s = '0;
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) s[127-8*k -: 8] = ref_sb[din[127-8*k -: 8]];
`ifdef SUB_BYTES_SHIFT_ROWS_EN
    for (int k = 0; k < 16; k++) begin
      int r = k % 4;
      int c = k / 4;
      int src = r + 4 * ((c + r) % 4);
      o[127-8*k -: 8] = s[127-8*src -: 8];
    end
`else
    o = s;
`endif
    return o;
  endfunction

  // Accept one block on the default instance, check latency/data, then drain it.
  task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
    int t = 0;
    int lat = 0;
    while (!dut_if.in_ready && t < 20) begin tick(); t++; end
    chk({name, " in_ready"}, 128'(dut_if.in_ready), 128'(1));
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = din;
    tick();
    dut_if.in_valid = 1'b0;
    dut_if.in_data  = {4{$urandom}};
    while (!dut_if.out_valid && lat < 20) begin tick(); lat++; end
    chk({name, " latency"}, 128'(lat), 128'(4));
    chk({name, " data"}, dut_if.out_data, exp);
    chk({name, " ready/busy in DONE"}, 128'({dut_if.in_ready, dut_busy}), 128'(2'b01));
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;
    chk({name, " back to IDLE"}, 128'({dut_if.in_ready, dut_if.out_valid, dut_busy}), 128'(3'b100));
  endtask

  initial begin
    logic [127:0] exp;
    logic [127:0] held;
    int lat;
    int lats [5];
    logic seen_bad;

    for (int i = 0; i < 256; i++) ref_sb[i] = sbox_model(8'(i));

    vecs[0] = '{"zeros", 128'h0, {16{8'h63}}, {16{8'h63}}};
    vecs[1] = '{"fips", 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808,
                128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[2] = '{"all_ff", {16{8'hff}}, {16{8'h16}}, {16{8'h16}}};
    vecs[3] = '{"ramp", 128'h00010203_04050607_08090a0b_0c0d0e0f,
                128'h637c777b_f26b6fc5_3001672b_fed7ab76,
                128'h636b6776_f201ab7b_30d777c5_fe7c6f2b};
    vecs[4] = '{"all_53", {16{8'h53}}, {16{8'hed}}, {16{8'hed}}};

    rst_n = 1'b0;
    dut_if.in_valid = 1'b0; dut_if.in_data = '0; dut_if.out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_in_data = '0; sw_out_ready = 1'b0;
    tick(); tick(); tick();
    chk("reset flags", 128'({dut_if.in_ready, dut_if.out_valid, dut_busy}), 128'(3'b100));
    chk("reset out_data", dut_if.out_data, 128'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int v = 0; v < 5; v++) begin
`ifdef SUB_BYTES_SHIFT_ROWS_EN
      exp = vecs[v].exp_sr;
`else
      exp = vecs[v].exp_sb;
`endif
      run_block(vecs[v].name, vecs[v].din, exp);
    end

    // Stall in DONE while the input side toggles; the held block must not move.
    exp = expected_of(vecs[1].din);
    dut_if.in_valid = 1'b1; dut_if.in_data = vecs[1].din;
    tick();
    dut_if.in_valid = 1'b0;
    lat = 0;
    while (!dut_if.out_valid && lat < 20) begin tick(); lat++; end
    chk("stall latency", 128'(lat), 128'(4));
    held = dut_if.out_data;
    for (int i = 0; i < 10; i++) begin
      dut_if.in_valid = 1'($urandom);
      dut_if.in_data  = {4{$urandom}};
      tick();
      chk("stall hold data", dut_if.out_data, exp);
      chk("stall flags", 128'({dut_if.out_valid, dut_if.in_ready}), 128'(2'b10));
    end
    chk("stall vs first look", dut_if.out_data, held);
    // Handshake edge with in_valid already high: no accept on that edge.
    dut_if.in_valid = 1'b1; dut_if.in_data = vecs[3].din; dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;
    chk("no accept on DONE->IDLE", 128'({dut_if.in_ready, dut_busy}), 128'(2'b10));
    tick();
    dut_if.in_valid = 1'b0;
    chk("accept one cycle later", 128'({dut_if.in_ready, dut_busy}), 128'(2'b01));
    lat = 0;
    while (!dut_if.out_valid && lat < 20) begin tick(); lat++; end
    chk("post-stall latency", 128'(lat), 128'(4));
    chk("post-stall data", dut_if.out_data, expected_of(vecs[3].din));
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;

    // Reset in the second BUSY cycle discards the block; in_valid under reset is ignored.
    dut_if.in_valid = 1'b1; dut_if.in_data = vecs[1].din;
    tick();
    dut_if.in_valid = 1'b0;
    tick();
    rst_n = 1'b0; dut_if.in_valid = 1'b1; dut_if.in_data = vecs[2].din;
    tick();
    chk("mid-busy reset flags", 128'({dut_if.in_ready, dut_if.out_valid, dut_busy}), 128'(3'b100));
    chk("mid-busy reset data", dut_if.out_data, 128'h0);
    tick();
    chk("in_valid under reset", 128'(dut_busy), 128'(0));
    rst_n = 1'b1; dut_if.in_valid = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dut_if.out_valid || dut_busy) seen_bad = 1'b1;
    end
    chk("discarded block never output", 128'(seen_bad), 128'(0));
    run_block("after reset", vecs[1].din, expected_of(vecs[1].din));

    // Byte sweep 0x00..0xff across all chunk widths.
    for (int b = 0; b < 16; b++) begin
      int t = 0;
      while (!(&sw_iready && sw_busy == 5'b0) && t < 20) begin tick(); t++; end
      chk("sweep ready", 128'(sw_iready), 128'(5'b11111));
      for (int k = 0; k < 16; k++) sw_in_data[127-8*k -: 8] = 8'(16 * b + k);
      exp = expected_of(sw_in_data);
      sw_in_valid = 1'b1;
      tick();
      sw_in_valid = 1'b0;
      for (int g = 0; g < 5; g++) lats[g] = 0;
      for (int e = 1; e <= 20 && !(&sw_ovalid); e++) begin
        tick();
        for (int g = 0; g < 5; g++) if (sw_ovalid[g] && lats[g] == 0) lats[g] = e;
      end
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("sweep blk%0d bpc%0d latency", b, 1 << g), 128'(lats[g]), 128'(16 >> g));
        chk($sformatf("sweep blk%0d bpc%0d data", b, 1 << g), sw_odata[g], exp);
      end
      sw_out_ready = 1'b1;
      tick();
      sw_out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 Parameter SHALL be: BYTES_PER_CYCLE, 4, bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset.
REQ-004 Port in_valid  input  1  in_data is valid.
REQ-005 Port in_ready  output  1  engine accepts a block this cycle.
REQ-006 Port in_data  input  128  AES state; byte k = in_data[127-8k -: 8]; byte k = row k%4, column k/4.
REQ-007 Port out_valid  output  1  out_data holds a finished block.
REQ-008 Port out_ready  input  1  downstream accepts out_data.
REQ-009 Port out_data  output  128  substituted state, same byte ordering as in_data.
REQ-010 Port busy  output  1  high in BUSY or DONE.

Function
REQ-011 FSM states SHALL be IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 IDLE: in_valid=1 at an edge captures in_data into a 128-bit state register, clears chunk counter to 0, enters BUSY.
REQ-014 BUSY: each cycle SHALL replace bytes [cnt*BYTES_PER_CYCLE, (cnt+1)*BYTES_PER_CYCLE-1] with the forward AES S-box value; cnt increments by 1.
REQ-015 BUSY: cnt = 16/BYTES_PER_CYCLE-1 SHALL write the final chunk and enter DONE; no wrap of cnt beyond this value.
REQ-016 Latency: out_valid SHALL rise exactly 16/BYTES_PER_CYCLE clock edges after the accepting edge (4 for default).
REQ-017 DONE: out_data and out_valid SHALL hold stable until out_ready=1; handshake edge returns to IDLE.
REQ-018 A new block SHALL NOT be accepted on the DONE->IDLE edge; earliest next accept is one cycle later (in_ready low in DONE).
REQ-019 in_valid/in_data changes during BUSY or DONE SHALL be ignored.
REQ-020 S-box SHALL be the FIPS-197 forward table, purely combinational, full 256-entry coverage.

Reset
REQ-021 rst_n=0 at an edge SHALL force IDLE, cnt=0, state register=0, from any state including mid-BUSY; an in-flight block is discarded, never output.
REQ-022 During and after reset: in_ready=1 (once rst_n=1 and in IDLE), out_valid=0, busy=0, out_data=0 (or ShiftRows of 0, also 0).
REQ-023 in_valid while rst_n=0 SHALL NOT be accepted.

Configuration
REQ-024 Macro SUB_BYTES_SHIFT_ROWS_EN defined: out_data byte (r,c) SHALL equal substituted byte (r,(c+r) mod 4), i.e. SubBytes followed by ShiftRows, same latency.
REQ-025 Macro undefined: out_data SHALL equal the substituted state register unpermuted; no ShiftRows logic present.

Structure
REQ-026 Shared package aes_pkg SHALL hold AES_BLOCK_W=128, AES_BYTE_W=8, AES_NUM_BYTES=16, byte typedef and the FSM state enum.
REQ-027 Sub-module sbox (8-bit in, 8-bit out, forward table) SHALL be instantiated BYTES_PER_CYCLE times; chunk selection by mux on cnt.

Verification
REQ-028 in_data=0x00000000_00000000_00000000_00000000 -> out_data all bytes 0x63 (no macro), 4 edges after accept.
REQ-029 in_data=0x193de3be_a0f4e22b_9ac68d2a_e9f84808 -> no macro: 0xd42711ae_e0bf98f1_b8b45de5_1e415230; with SUB_BYTES_SHIFT_ROWS_EN: 0xd4bf5d30_e0b452ae_b84111f1_1e2798e5.
REQ-030 Sweep BYTES_PER_CYCLE 1,2,4,8,16 with bytes 0x00..0xff over 16 blocks -> each byte matches reference table (0x53->0xed, 0xff->0x16); out_valid at 16,8,4,2,1 edges.
REQ-031 Hold out_ready=0 for 10 cycles in DONE, toggle in_valid/in_data -> out_data stable, in_ready=0, no second capture; out_ready=1 -> IDLE, next accept no earlier than one cycle later.
REQ-032 Assert rst_n=0 during BUSY cycle 2 -> next cycle IDLE, out_valid never rises for that block; following block processes correctly.
